// File: rtl/ifid_fetch_buffer_pkg.sv
// ifid_fetch_buffer_pkg: shared pipeline defines (bubble instruction, opcodes, skid state)
package ifid_fetch_buffer_pkg;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI     = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC   = 7'b0010111;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [6:0]  OP_JALR    = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]  OP_LOAD    = 7'b0000011;
    localparam logic [6:0]  OP_STORE   = 7'b0100011;
    localparam logic [6:0]  OP_IMM     = 7'b0010011;
    localparam logic [6:0]  OP_REG     = 7'b0110011;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/ifid_skid_reg.sv
// ifid_skid_reg: one-entry skid buffer holding an instruction and its PC
module ifid_skid_reg
    import ifid_fetch_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        full_o
);
    skid_state_e state_q, state_d;
    logic [31:0] instr_q, instr_d, pc_q, pc_d;

    // clear wins, a load (even with a simultaneous unload) leaves the entry full
    always_comb begin
        state_d = clear_i ? SKID_EMPTY : load_i ? SKID_FULL : unload_i ? SKID_EMPTY : state_q;
        instr_d = (load_i && !clear_i) ? instr_i : instr_q;
        pc_d    = (load_i && !clear_i) ? pc_i : pc_q;
    end

    // state and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign full_o  = (state_q == SKID_FULL);
endmodule

// File: rtl/ifid_fetch_buffer.sv
// ifid_fetch_buffer: PC register, IF/ID pipeline register and stall skid buffer
module ifid_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = ifid_fetch_buffer_pkg::NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iready_n,
    input  logic [31:0] IDT,
    output logic [31:0] IAD,
    input  logic        stall_ID,
    input  logic        branch_PC_contral,
    input  logic [31:0] branch_target,
    output logic [31:0] Instraction_pype,
    output logic [31:0] PC_pype,
    output logic        valid_pype
);
    import ifid_fetch_buffer_pkg::*;

    logic [31:0] pc_q, pc_d, instr_q, instr_d, ppc_q, ppc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr, skid_pc;
    logic        skid_full, skid_load, skid_unload, fetch;

    // a fetch is taken only when memory answers and there is somewhere to put it
    assign fetch = !branch_PC_contral && !iready_n && (!skid_full || !stall_ID);

    // next PC / IF/ID contents and skid controls
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        ppc_d       = ppc_q;
        valid_d     = valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        if (branch_PC_contral) begin
            pc_d    = branch_target;
            instr_d = NOP_INSN;
            valid_d = 1'b0;
        end else begin
            if (fetch) pc_d = pc_next(pc_q);
            if (stall_ID) begin
                skid_load = fetch;
            end else if (skid_full) begin
                instr_d     = skid_instr;
                ppc_d       = skid_pc;
                valid_d     = 1'b1;
                skid_unload = 1'b1;
                skid_load   = fetch;
            end else begin
                instr_d = fetch ? IDT : NOP_INSN;
                ppc_d   = fetch ? pc_q : ppc_q;
                valid_d = fetch;
            end
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSN;
            ppc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ppc_q   <= ppc_d;
            valid_q <= valid_d;
        end
    end

    ifid_skid_reg u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (branch_PC_contral),
        .instr_i  (IDT),
        .pc_i     (pc_q),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc),
        .full_o   (skid_full)
    );

    assign IAD              = pc_q;
    assign Instraction_pype = instr_q;
    assign PC_pype          = ppc_q;
    assign valid_pype       = valid_q;
endmodule

// File: tb/tb_ifid_fetch_buffer.sv
// tb_ifid_fetch_buffer: queue-model checked bench for the fetch buffer
module tb_ifid_fetch_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iready_n = 1'b1;
    logic        stall_ID = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic [31:0] IDT, IAD, instr, ppc;
    logic        valid;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign IDT = iready_n ? 32'hDEAD_BEEF : mem(IAD);

    ifid_fetch_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .iready_n          (iready_n),
        .IDT               (IDT),
        .IAD               (IAD),
        .stall_ID          (stall_ID),
        .branch_PC_contral (br),
        .branch_target     (tgt),
        .Instraction_pype  (instr),
        .PC_pype           (ppc),
        .valid_pype        (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending fetched instructions live in a queue; decode
    // takes the oldest when not stalled, memory is asked only if the queue has room.
    logic [31:0] m_pc, m_instr, m_ppc;
    logic        m_valid;
    logic [63:0] m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_ppc = 32'h0; m_valid = 1'b0;
            m_q.delete();
        end else if (br) begin
            m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
            m_q.delete();
        end else begin
            if (!iready_n && (m_q.size() == 0 || !stall_ID)) begin
                m_q.push_back({mem(m_pc), m_pc});
                m_pc = m_pc + 32'd4;
            end
            if (!stall_ID) begin
                if (m_q.size() > 0) begin
                    logic [63:0] e;
                    e = m_q.pop_front();
                    m_instr = e[63:32]; m_ppc = e[31:0]; m_valid = 1'b1;
                end else begin
                    m_instr = NOP; m_valid = 1'b0;
                end
            end
        end
    end

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("IAD", IAD, m_pc);
            chk("instr", instr, m_instr);
            chk("valid", {31'b0, valid}, {31'b0, m_valid});
            if (m_valid) chk("PC_pype", ppc, m_ppc);
        end
    end

    task automatic cyc(input logic rn, input logic st, input logic b, input logic [31:0] t);
        iready_n = rn; stall_ID = st; br = b; tgt = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_IAD", IAD, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_ppc", ppc, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        rst = 1'b0;
        // straight-line fetch
        cyc(0, 0, 0, 0);
        chk("seq_A", instr, 32'hC0DE0000); chk("seq_IAD4", IAD, 32'h4);
        chk("seq_validA", {31'b0, valid}, 32'h1);
        cyc(0, 0, 0, 0);
        chk("seq_B", instr, 32'hC0DE0004); chk("seq_IAD8", IAD, 32'h8);
        // stall fills skid, then holds
        cyc(0, 1, 0, 0);
        chk("stall_IAD", IAD, 32'hC); chk("stall_hold", instr, 32'hC0DE0004);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("stall_IAD2", IAD, 32'hC); chk("stall_hold2", instr, 32'hC0DE0004);
        cyc(0, 0, 0, 0);
        chk("unskid", instr, 32'hC0DE0008); chk("unskid_pc", ppc, 32'h8);
        chk("unskid_IAD", IAD, 32'h10);
        cyc(1, 0, 0, 0);
        chk("drain", instr, 32'hC0DE000C);
        cyc(1, 0, 0, 0);
        chk("bubble", instr, NOP); chk("bubble_v", {31'b0, valid}, 32'h0);
        // branch with skid full and stall
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h100);
        chk("br_IAD", IAD, 32'h100); chk("br_v", {31'b0, valid}, 32'h0);
        cyc(0, 0, 0, 0);
        chk("br_first", instr, 32'hC0DE0100); chk("br_ppc", ppc, 32'h100);
        // memory not ready
        repeat (4) cyc(1, 0, 0, 0);
        chk("nr_instr", instr, NOP); chk("nr_IAD", IAD, 32'h104);
        cyc(0, 0, 0, 0);
        chk("nr_resume", instr, 32'hC0DE0104);
        // address wrap
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("wrap_IAD", IAD, 32'h0); chk("wrap_ppc", ppc, 32'hFFFF_FFFC);
        // reset while skid full
        cyc(0, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_IAD", IAD, 32'h0); chk("arst_v", {31'b0, valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        chk("arst_nostale", {31'b0, valid}, 32'h0);
        cyc(0, 0, 0, 0);
        chk("arst_first", instr, 32'hC0DE0000); chk("arst_ppc", ppc, 32'h0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0,
                ($urandom_range(0, 1) == 0) ? ($urandom() & 32'hFFFF_FFFC) : 32'hFFFF_FFF0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
